// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon plaintext-side packer: state encoding,
// default block width and the byte-count width derivations.
package ascon_pkg;

    localparam int BLK_SIZE_DEF = 64;

    // Packer FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PACK  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Bytes per block
    function automatic int calc_nb(input int blk_size);
        return blk_size / 8;
    endfunction

    // Width of a count that must hold 0..NB inclusive
    function automatic int calc_nbw(input int blk_size);
        return $clog2(blk_size / 8) + 1;
    endfunction

endpackage

// File: rtl/blk_slot.sv
// One-entry output register for packed blocks. Holds data, byte count and
// last flag stable while valid is high and the consumer is not ready.
module blk_slot #(
    parameter int BLK_SIZE = 64,
    parameter int NBW      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [BLK_SIZE-1:0] load_data_i,
    input  logic [NBW-1:0]      load_nbytes_i,
    input  logic                load_last_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [BLK_SIZE-1:0] data_o,
    output logic [NBW-1:0]      nbytes_o,
    output logic                last_o,
    output logic                free_o
);

    logic                valid_q;
    logic [BLK_SIZE-1:0] data_q;
    logic [NBW-1:0]      nbytes_q;
    logic                last_q;

    // A handshake in the same cycle as a load frees the slot for the new entry
    assign free_o = ~valid_q | ready_i;

    // Slot register: load wins over handshake so valid stays high back-to-back
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the payload is reset as well, since the block output must read zero out of reset.
            valid_q  <= 1'b0;
            data_q   <= '0;
            nbytes_q <= '0;
            last_q   <= 1'b0;
        end else if (load_i) begin
            valid_q  <= 1'b1;
            data_q   <= load_data_i;
            nbytes_q <= load_nbytes_i;
            last_q   <= load_last_i;
        end else if (ready_i) begin
            valid_q  <= 1'b0;
        end
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign nbytes_o = nbytes_q;
    assign last_o   = last_q;

endmodule

// File: rtl/ascon_blk_packer.sv
// Byte-stream to block packer feeding the cipher plaintext port. Bytes are
// assembled MSB-first; a finished block moves into the output slot, or waits
// in the assembly register (afull) while the slot is still occupied.
module ascon_blk_packer
    import ascon_pkg::*;
#(
    parameter int BLK_SIZE = BLK_SIZE_DEF,
    parameter int NBW      = calc_nbw(BLK_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    input  logic                in_last,
    input  logic                in_flush,
    output logic                in_ready,
    output logic [BLK_SIZE-1:0] blk_data,
    output logic [NBW-1:0]      blk_nbytes,
    output logic                blk_last,
    output logic                blk_valid,
    input  logic                blk_ready,
    output logic                busy
);

    localparam int             NB     = calc_nb(BLK_SIZE);
    localparam logic [NBW-1:0] NB_CNT = NBW'(NB);

    logic [1:0]          state_q, state_d;
    logic [NBW-1:0]      acnt_q, acnt_d;
    logic [BLK_SIZE-1:0] asm_data_q, asm_data_d;
    logic                asm_last_q, asm_last_d;
    logic                afull_q, afull_d;

    logic                accept, flush_acc, byte_acc;
    logic [BLK_SIZE-1:0] cmp_data;
    logic [NBW-1:0]      cmp_nbytes;
    logic                cmp_last, complete;
    logic                slot_free, slot_load;
    logic [BLK_SIZE-1:0] load_data;
    logic [NBW-1:0]      load_nbytes;
    logic                load_last;

    // Input acceptance and the assembly contents after this cycle's byte/flush
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        in_ready   = (state_q == ST_PACK) & ~afull_q;
        accept     = in_valid & in_ready;
        flush_acc  = accept & in_flush;
        byte_acc   = accept & ~in_flush;
        cmp_data   = asm_data_q;
        for (int i = 0; i < NB; i++) begin
            if (byte_acc && acnt_q == NBW'(i)) begin
                cmp_data[BLK_SIZE-1-8*i -: 8] = in_data;
            end
        end
        cmp_nbytes = byte_acc ? acnt_q + NBW'(1) : acnt_q;
        cmp_last   = flush_acc | (byte_acc & in_last);
        complete   = flush_acc | (byte_acc & ((cmp_nbytes == NB_CNT) | in_last));
    end

    // Slot load source: a parked block has priority (no completion can occur while parked)
    always_comb begin
        slot_load   = slot_free & (afull_q | complete);
        load_data   = afull_q ? asm_data_q : cmp_data;
        load_nbytes = afull_q ? acnt_q     : cmp_nbytes;
        load_last   = afull_q ? asm_last_q : cmp_last;
    end

    // Next-state for the FSM and the assembly register
    always_comb begin
        state_d    = state_q;
        acnt_d     = acnt_q;
        asm_data_d = asm_data_q;
        asm_last_d = asm_last_q;
        afull_d    = afull_q;

        case (state_q)
            ST_IDLE:  if (start) state_d = ST_PACK;
            ST_PACK:  if (complete && cmp_last) state_d = ST_DRAIN;
            ST_DRAIN: if (blk_valid && blk_ready && blk_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (slot_load) begin
            acnt_d     = '0;
            asm_data_d = '0;
            asm_last_d = 1'b0;
            afull_d    = 1'b0;
        end else if (complete) begin
            asm_data_d = cmp_data;
            acnt_d     = cmp_nbytes;
            asm_last_d = cmp_last;
            afull_d    = 1'b1;
        end else if (byte_acc) begin
            asm_data_d = cmp_data;
            acnt_d     = cmp_nbytes;
        end
    end

    // FSM and assembly registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            acnt_q     <= '0;
            asm_data_q <= '0;
            asm_last_q <= 1'b0;
            afull_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acnt_q     <= acnt_d;
            asm_data_q <= asm_data_d;
            asm_last_q <= asm_last_d;
            afull_q    <= afull_d;
        end
    end

    blk_slot #(
        .BLK_SIZE (BLK_SIZE),
        .NBW      (NBW)
    ) u_slot (
        .clk           (clk),
        .rst           (rst),
        .load_i        (slot_load),
        .load_data_i   (load_data),
        .load_nbytes_i (load_nbytes),
        .load_last_i   (load_last),
        .ready_i       (blk_ready),
        .valid_o       (blk_valid),
        .data_o        (blk_data),
        .nbytes_o      (blk_nbytes),
        .last_o        (blk_last),
        .free_o        (slot_free)
    );

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ascon_blk_packer.sv
// Directed bench for ascon_blk_packer: a byte-level model pushes expected
// blocks into a scoreboard and a monitor pops them on every block handshake.
module tb_ascon_blk_packer;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  nbytes;
        logic        last;
    } blk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_flush;
    logic        in_ready;
    logic [63:0] blk_data;
    logic [3:0]  blk_nbytes;
    logic        blk_last;
    logic        blk_valid;
    logic        blk_ready;
    logic        busy;

    int tests = 0;
    int fails = 0;

    blk_t        sb[$];
    logic [63:0] m_data;
    int          m_cnt;

    always #5 clk = ~clk;

    ascon_blk_packer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_flush   (in_flush),
        .in_ready   (in_ready),
        .blk_data   (blk_data),
        .blk_nbytes (blk_nbytes),
        .blk_last   (blk_last),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    // Monitor: a handshake happens on the next rising edge whenever valid&ready here
    always @(negedge clk) begin
        if (rst && blk_valid && blk_ready) begin
            if (sb.size() == 0) begin
                timeout_fail("unexpected_block");
            end else begin
                blk_t e;
                e = sb.pop_front();
                check("blk_data",   blk_data,          e.data);
                check("blk_nbytes", 64'(blk_nbytes),   64'(e.nbytes));
                check("blk_last",   64'(blk_last),     64'(e.last));
            end
        end
    end

    task automatic model_clear();
        m_data = '0;
        m_cnt  = 0;
    endtask

    task automatic push_blk(input bit last);
        blk_t e;
        e.data   = m_data;
        e.nbytes = 4'(m_cnt);
        e.last   = last;
        sb.push_back(e);
        model_clear();
    endtask

    // Present a byte or flush (from #1 after an edge) until it is accepted
    task automatic send(input logic [7:0] b, input bit last, input bit flush);
        bit ok;
        int cyc;
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        in_flush = flush;
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_flush = 1'b0;
        if (!ok) begin
            timeout_fail("send");
        end else if (flush) begin
            push_blk(1'b1);
        end else begin
            m_data[63-8*m_cnt -: 8] = b;
            m_cnt++;
            if (m_cnt == 8 || last) push_blk(last);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while ((busy || sb.size() != 0) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 200) timeout_fail(tag);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_flush  = 1'b0;
        blk_ready = 1'b1;
        model_clear();

        // Reset values
        #12;
        check("rst_in_ready",  64'(in_ready),   64'd0);
        check("rst_blk_valid", 64'(blk_valid),  64'd0);
        check("rst_blk_last",  64'(blk_last),   64'd0);
        check("rst_nbytes",    64'(blk_nbytes), 64'd0);
        check("rst_blk_data",  blk_data,        64'd0);
        check("rst_busy",      64'(busy),       64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // in_valid in IDLE is ignored
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("idle_busy",     64'(busy),      64'd0);
        check("idle_in_ready", 64'(in_ready),  64'd0);
        check("idle_valid",    64'(blk_valid), 64'd0);

        // 16 bytes, two full blocks, last on the 16th
        pulse_start();
        check("start_busy",     64'(busy),     64'd1);
        check("start_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 16; i++) send(8'(i), i == 15, 1'b0);
        @(negedge clk);
        check("t1_drain_busy",  64'(busy),      64'd1);
        check("t1_drain_ready", 64'(in_ready),  64'd0);
        check("t1_last_valid",  64'(blk_valid), 64'd1);
        @(posedge clk);
        #1;
        check("t1_busy_drop",   64'(busy),      64'd0);
        check("t1_sb_empty",    64'(sb.size()), 64'd0);

        // Short last block
        pulse_start();
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        send(8'hCC, 1'b1, 1'b0);
        wait_idle("t2_idle");

        // Immediate flush, then a start during busy must be ignored
        pulse_start();
        send(8'hE7, 1'b1, 1'b1);
        start = 1'b1;
        @(negedge clk);
        check("t3_flush_valid", 64'(blk_valid),  64'd1);
        check("t3_flush_nb",    64'(blk_nbytes), 64'd0);
        check("t3_flush_data",  blk_data,        64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t3_busy_drop",   64'(busy),     64'd0);
        @(posedge clk);
        #1;
        check("t3_start_ign",   64'(busy),     64'd0);
        check("t3_in_ready",    64'(in_ready), 64'd0);

        // Back-pressure: 24 bytes with blk_ready low for 10 cycles
        blk_ready = 1'b0;
        pulse_start();
        fork
            begin
                for (int i = 0; i < 24; i++) send(8'h40 + 8'(i), i == 23, 1'b0);
            end
            begin
                int cyc;
                cyc = 0;
                while (!blk_valid && cyc < 100) begin
                    @(negedge clk);
                    cyc++;
                end
                if (!blk_valid) timeout_fail("t4_first_valid");
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    check("t4_hold_data",  blk_data,        64'h4041424344454647);
                    check("t4_hold_valid", 64'(blk_valid),  64'd1);
                end
                check("t4_afull_ready", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                blk_ready = 1'b1;
            end
        join
        wait_idle("t4_idle");

        // Reset mid-message discards partial data
        pulse_start();
        for (int i = 0; i < 5; i++) send(8'h70 + 8'(i), 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        model_clear();
        check("t5_in_ready",  64'(in_ready),   64'd0);
        check("t5_blk_valid", 64'(blk_valid),  64'd0);
        check("t5_busy",      64'(busy),       64'd0);
        check("t5_blk_data",  blk_data,        64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        pulse_start();
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        wait_idle("t5_idle");

        // 9 bytes: handshake of block 1 coincides with completion of block 2
        pulse_start();
        for (int i = 0; i < 9; i++) send(8'(i), i == 8, 1'b0);
        @(negedge clk);
        check("t6_valid_cont", 64'(blk_valid),  64'd1);
        check("t6_nbytes",     64'(blk_nbytes), 64'd1);
        check("t6_data",       blk_data,        64'h0800000000000000);
        wait_idle("t6_idle");

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
